// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and constants for the mux scan sequencer
// Purpose: FSM state enum, settle counter width, default geometry and a
//          constant clog2 used for elaboration-time parameter checks.
// Ports:   none (package).
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int SETTLE_W   = 4;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_SEL_W  = 2;

  // Smallest r with 2**r >= n; evaluated at elaboration only.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - scan request, mux select/output and word handshake bundle
// Purpose: groups every non-clock signal of mux_scan_ctrl.
// Ports:   start (req in), busy (out), sel (to mux tree), mux_out (from mux tree),
//          data/valid (word out), ready (downstream accept).
//          master = sequencer side, slave = requester / mux tree / consumer side.
interface mux_scan_ctrl_if
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W
);

  logic              start;
  logic              busy;
  logic [SEL_W-1:0]  sel;
  logic              mux_out;
  logic [NUM_CH-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    input  start, mux_out, ready,
    output busy, sel, data, valid
  );

  modport slave (
    output start, mux_out, ready,
    input  busy, sel, data, valid
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// rtl/mux_scan_ctrl_settle_timer.sv - loadable down-counter timing mux settling
// Purpose: load captures value; counts down to zero; expire flags the last
//          settle cycle (count == 1) so the FSM moves to SAMPLE on that edge.
// Ports:   clk, rst (async high), load, value[SETTLE_W-1:0], expire.
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                expire
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == SETTLE_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps a NUM_CH:1 mux select and assembles one sample word
// Purpose: on start, walks sel 0..NUM_CH-1, waits SETTLE cycles after each
//          select change, samples mux_out, then offers the word on data/valid
//          until ready. All outputs come straight from flops.
// Ports:   clk, rst (async high), bus (mux_scan_ctrl_if.master).
// Option:  MUX_SCAN_CONT_EN - after each handshake start the next scan at once
//          instead of returning to IDLE.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.master bus
);

  if (SEL_W != clog2(NUM_CH) || NUM_CH < 2 || NUM_CH > 64 || (1 << SEL_W) != NUM_CH) begin : g_bad_geometry
    $error("mux_scan_ctrl: NUM_CH must be a power of two in 2..64 and SEL_W == clog2(NUM_CH)");
  end
  if (SETTLE < 0 || SETTLE > (1 << SETTLE_W) - 1) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE out of range");
  end

  // With SETTLE == 0 every scan step goes straight to SAMPLE and the timer idles.
  localparam state_t   SCAN_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic     SETTLE_ON  = (SETTLE != 0);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  state_t            state_q, state_next;
  logic [SEL_W-1:0]  sel_q, sel_next;
  logic [NUM_CH-1:0] shadow_q, shadow_next;
  logic [NUM_CH-1:0] data_q, data_next;
  logic              valid_q, valid_next;
  logic              busy_q;
  logic              timer_load;
  logic              timer_expire;

  settle_timer u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .value  (SETTLE_W'(SETTLE)),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_next;
      sel_q    <= sel_next;
      shadow_q <= shadow_next;
      data_q   <= data_next;
      valid_q  <= valid_next;
      // Registered from next state so busy lines up with the state register.
      busy_q   <= (state_next != ST_IDLE);
    end
  end

  always_comb begin
    state_next  = state_q;
    sel_next    = sel_q;
    shadow_next = shadow_q;
    data_next   = data_q;
    valid_next  = valid_q;
    timer_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_next = '0;
        if (bus.start) begin
          state_next = SCAN_ENTRY;
          timer_load = SETTLE_ON;
        end
      end

      ST_SETTLE: begin
        if (timer_expire) begin
          state_next = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        shadow_next[sel_q] = bus.mux_out;
        if (sel_q != LAST_SEL) begin
          sel_next   = sel_q + 1'b1;
          state_next = SCAN_ENTRY;
          timer_load = SETTLE_ON;
        end else begin
          // Last bit bypasses the shadow so the word is complete this edge.
          data_next             = shadow_q;
          data_next[NUM_CH-1]   = bus.mux_out;
          valid_next            = 1'b1;
          state_next            = ST_DONE;
        end
      end

      ST_DONE: begin
        // start is deliberately not looked at here; it is never queued.
        if (bus.ready) begin
          valid_next = 1'b0;
          sel_next   = '0;
`ifdef MUX_SCAN_CONT_EN
          state_next = SCAN_ENTRY;
          timer_load = SETTLE_ON;
`else
          state_next = ST_IDLE;
`endif
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.sel   = sel_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl (SETTLE 1, 0, 3; MUX_SCAN_CONT_EN aware)
module tb_mux_scan_ctrl;

  localparam int NCH = 4;
`ifdef MUX_SCAN_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start_v;
  logic [2:0] ready_v;
  logic [3:0] mux_in;

  int checks = 0;
  int errors = 0;

  logic [1:0] d_sel   [3];
  logic       d_busy  [3];
  logic       d_valid [3];
  logic [3:0] d_data  [3];

  always #5 clk = ~clk;

  mux_scan_ctrl_if #(.NUM_CH(NCH), .SEL_W(2)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_scan_ctrl #(
      .NUM_CH (NCH),
      .SEL_W  (2),
      .SETTLE ((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
    // mux_4 model: output is the input addressed by sel
    assign bus[g].mux_out = mux_in[bus[g].sel];
    assign bus[g].start   = start_v[g];
    assign bus[g].ready   = ready_v[g];
    assign d_sel[g]   = bus[g].sel;
    assign d_busy[g]  = bus[g].busy;
    assign d_valid[g] = bus[g].valid;
    assign d_data[g]  = bus[g].data;
  end

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: k counts clock edges since the scan was accepted;
  // channel ch is sampled at edge (ch+1)*(SETTLE+1), so sel during cycle k is k/(SETTLE+1).
  int         m_k     [3] = '{0, 0, 0};
  bit         m_busy  [3] = '{0, 0, 0};
  bit         m_valid [3] = '{0, 0, 0};
  logic [3:0] m_data  [3] = '{4'h0, 4'h0, 4'h0};
  logic [3:0] m_word  [3] = '{4'h0, 4'h0, 4'h0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_k[i] = 0; m_busy[i] = 0; m_valid[i] = 0; m_data[i] = '0; m_word[i] = '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!m_busy[i]) begin
          if (start_v[i]) begin
            m_busy[i] = 1; m_k[i] = 0;
          end
        end else if (m_valid[i]) begin
          if (ready_v[i]) begin
            m_valid[i] = 0;
            if (CONT) m_k[i] = 0;
            else      m_busy[i] = 0;
          end
        end else begin
          m_k[i]++;
          if (m_k[i] % (settle_of(i) + 1) == 0) begin
            int ch;
            ch = m_k[i] / (settle_of(i) + 1) - 1;
            m_word[i][ch] = mux_in[ch];
            if (ch == NCH - 1) begin
              m_data[i]  = m_word[i];
              m_valid[i] = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [1:0] esel;
      esel = m_valid[i] ? 2'(NCH - 1) : m_busy[i] ? 2'(m_k[i] / (settle_of(i) + 1)) : 2'd0;
      chk($sformatf("model_sel[%0d]", i),   d_sel[i],   esel);
      chk($sformatf("model_busy[%0d]", i),  d_busy[i],  m_busy[i]);
      chk($sformatf("model_valid[%0d]", i), d_valid[i], m_valid[i]);
      chk($sformatf("model_data[%0d]", i),  d_data[i],  m_data[i]);
    end
  end

  task automatic run_scan(input int i, input logic [3:0] pat, output int lat, output logic [3:0] word);
    mux_in = pat; ready_v[i] = 1'b1; start_v[i] = 1'b1;
    lat = -1; word = '0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) start_v[i] = 1'b0;
      if (d_valid[i]) begin
        lat = c - 1; word = d_data[i];
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, lat1, lat2, n;
    logic [3:0] w, w1, w2;
    int         seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    rst = 1'b1; start_v = '0; ready_v = '0; mux_in = '0;
    repeat (2) @(negedge clk);
    chk("reset_sel", d_sel[0], 0);
    chk("reset_busy", d_busy[0], 0);
    chk("reset_valid", d_valid[0], 0);
    chk("reset_data", d_data[0], 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef MUX_SCAN_CONT_EN
    begin
      logic [3:0] pats [3] = '{4'b1010, 4'b0011, 4'b1110};
      int wi;
      wi = 0;
      mux_in = pats[0]; ready_v[0] = 1'b1; start_v[0] = 1'b1;
      for (int c = 1; c <= 60 && wi < 3; c++) begin
        @(negedge clk);
        if (c == 1) start_v[0] = 1'b0;
        chk("cont_busy", d_busy[0], 1);
        if (d_valid[0]) begin
          chk("cont_valid_cycle", c - 1, 8 + 8 * wi);
          chk("cont_data", d_data[0], pats[wi]);
          if (wi < 2) mux_in = pats[wi + 1];
          wi++;
        end
      end
      chk("cont_words_seen", wi, 3);
    end
`else
    // scan of 1010 with ready=1: sel sequence, latency 8, one-cycle valid
    mux_in = 4'b1010; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("t1_sel_c%0d", c), d_sel[0], seq[c]);
      chk($sformatf("t1_valid_low_c%0d", c), d_valid[0], 0);
    end
    @(negedge clk);
    chk("t1_valid_c8", d_valid[0], 1);
    chk("t1_data", d_data[0], 4'b1010);
    @(negedge clk);
    chk("t1_valid_c9", d_valid[0], 0);
    chk("t1_busy_c9", d_busy[0], 0);

    // backpressure: valid/data held, start ignored, start with handshake dropped
    ready_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (!d_valid[0] && n < 40) begin
      @(negedge clk); n++;
    end
    chk("t2_valid_seen", d_valid[0], 1);
    for (int c = 0; c < 5; c++) begin
      start_v[0] = c[0];
      @(negedge clk);
      chk("t2_valid_held", d_valid[0], 1);
      chk("t2_data_held", d_data[0], 4'b1010);
    end
    start_v[0] = 1'b1; ready_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("t2_valid_drop", d_valid[0], 0);
    chk("t2_busy_after", d_busy[0], 0);
    @(negedge clk);
    chk("t2_start_not_queued", d_busy[0], 0);
    chk("t2_data_kept", d_data[0], 4'b1010);

    // SETTLE=0 and SETTLE=3 latency
    mux_in = 4'b0110; ready_v[1] = 1'b1; ready_v[2] = 1'b1;
    start_v[1] = 1'b1; start_v[2] = 1'b1;
    lat1 = -1; lat2 = -1; w1 = '0; w2 = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin start_v[1] = 1'b0; start_v[2] = 1'b0; end
      if (d_valid[1] && lat1 < 0) begin lat1 = c - 1; w1 = d_data[1]; end
      if (d_valid[2] && lat2 < 0) begin lat2 = c - 1; w2 = d_data[2]; end
    end
    chk("t3_lat_settle0", lat1, 4);
    chk("t3_data_settle0", w1, 4'b0110);
    chk("t3_lat_settle3", lat2, 16);
    chk("t3_data_settle3", w2, 4'b0110);

    // async reset mid-scan
    mux_in = 4'b1010; ready_v[0] = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (d_sel[0] != 2'd2 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("t4_sel2_reached", d_sel[0], 2);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_sel", d_sel[0], 0);
    chk("t4_rst_valid", d_valid[0], 0);
    chk("t4_rst_busy", d_busy[0], 0);
    chk("t4_rst_data", d_data[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_scan(0, 4'b1100, lat, w);
    chk("t4_rescan_lat", lat, 8);
    chk("t4_rescan_data", w, 4'b1100);

    // successive words with changed inputs
    run_scan(0, 4'b1111, lat, w);
    chk("t5_word1", w, 4'b1111);
    run_scan(0, 4'b0001, lat, w);
    chk("t5_word2", w, 4'b0001);
    chk("t5_lat2", lat, 8);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
